data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Handshaked data-memory responder that serves load/store requests from a bus initiator, such as a multicycle or pipelined CPU core's LSU.
- Replaces the combinational data memory with a valid/ready request channel and a valid/ready response channel.
- Supports a configurable fixed access latency, byte strobes and error signalling for misaligned or out-of-range addresses.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two, minimum 4.
- LATENCY, 2, wait cycles between request acceptance and response; 0 to 15 allowed.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte lanes follow req_wstrb.
- req_wstrb  input  4  byte enables for a store; bit i selects req_wdata[8i+7:8i]; ignored on a load.
- resp_valid  output  1  response is available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Wait counter cleared; all DEPTH_WORDS words cleared to 0.
  - Reset overrides any in-flight request; a store not yet committed is discarded.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, capture write, addr, wdata and wstrb.
  - If LATENCY=0, go to RESP; otherwise load the counter with LATENCY and go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When the counter reaches 1, perform the access at that edge and go to RESP.
  - With LATENCY=0, the access is performed at the acceptance edge.
- Access (exactly one per accepted request):
  - Address is in range if BASE_ADDR <= addr < BASE_ADDR+DEPTH_WORDS*4, using 32-bit unsigned compare with no wrap.
  - Misaligned (addr[1:0]!=0) or out of range: err=1, rdata=0, memory unchanged.
  - Word index = (addr-BASE_ADDR)>>2.
  - Store: each lane with wstrb[i]=1 is updated; other lanes are unchanged; wstrb=4'b0000 is a legal no-op with err=0; rdata=0.
  - Load: rdata = word, err=0.
- RESP:
  - resp_valid=1; req_ready=0.
  - resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake, return to IDLE; resp_valid=0 and req_ready=1 from the next cycle.
- Latency and throughput:
  - resp_valid first asserts LATENCY+1 cycles after the acceptance edge when resp_ready is held high.
  - One outstanding request at a time.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- Request-channel rules:
  - Request fields are sampled only at acceptance; changes while req_ready=0 are ignored.
  - req_valid may drop without acceptance with no effect.
- Memory view:
  - A load issued immediately after a store to the same word returns the stored data, because the store commits before its response.
  - Memory is never read or written outside the access edge.

Test Plan:
- Reset, then load at 0x0000_0010 with LATENCY=2 and resp_ready=1 -> resp_valid in cycle 3 after acceptance, rdata=0, err=0; req_ready=0 until the cycle after the handshake.
- Store 0xDEADBEEF to 0x20 with wstrb=1111, then store 0x00000055 with wstrb=0001, then load 0x20 -> rdata=0xDEADBE55, err=0.
- Load at 0x22 (misaligned) and load at 0x400 with DEPTH_WORDS=256 -> err=1 and rdata=0 for both; a following store to 0x400 leaves word 0 unchanged (load 0x0 returns its prior value).
- Backpressure: load with resp_ready=0 for 5 cycles after resp_valid -> resp_valid, rdata and err held constant, req_valid pulses are not accepted; then resp_ready=1 -> single handshake, IDLE next cycle.
- Assert rst during WAIT of a store of 0x12345678 to 0x8 -> next cycle req_ready=1 and resp_valid=0; a load of 0x8 returns 0x00000000.
- LATENCY=0: back-to-back loads with req_valid and resp_ready held high -> one response every 2 cycles, resp_valid one cycle after each acceptance.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    // Initiator side (e.g. a CPU LSU).
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Responder side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Handshaked data memory: one outstanding load/store, fixed access latency,
// byte strobes, error response for misaligned or out-of-range addresses.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    data_mem_if.slave  bus
);
    localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LatCnt    = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic            acc_en;
    logic            acc_write;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_wstrb;
    logic [31:0]     acc_off;
    logic            acc_err;
    logic [IdxW-1:0] acc_idx;
    logic [31:0]     acc_word;
    logic [31:0]     acc_wword;
    logic [31:0]     acc_rdata;
    logic            acc_we;

    // Access decode: with zero latency the access uses the live request fields at acceptance.
    always_comb begin
        acc_en    = ((state_q == StIdle) && bus.req_valid && (LATENCY == 0)) ||
                    ((state_q == StWait) && (cnt_q == 4'd1));
        acc_write = (state_q == StIdle) ? bus.req_write : write_q;
        acc_addr  = (state_q == StIdle) ? bus.req_addr  : addr_q;
        acc_wdata = (state_q == StIdle) ? bus.req_wdata : wdata_q;
        acc_wstrb = (state_q == StIdle) ? bus.req_wstrb : wstrb_q;
        acc_off   = acc_addr - BASE_ADDR;
        // Low-bound check is done separately so the subtraction never wraps into range.
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                    ({1'b0, acc_off} >= SpanBytes);
        acc_idx   = acc_off[IdxW+1:2];
        acc_word  = mem_q[acc_idx];
        acc_wword = acc_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_wstrb[i]) begin
                acc_wword[8*i +: 8] = acc_wdata[8*i +: 8];
            end
        end
        acc_we    = acc_write && !acc_err;
        acc_rdata = (acc_write || acc_err) ? 32'h0 : acc_word;
    end

    // Control FSM with registered handshake outputs; the memory commits at the access edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wstrb_q     <= bus.req_wstrb;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            cnt_q   <= LatCnt;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd1) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        rdata_q      <= 32'h0;
                        err_q        <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (acc_en) begin
                rdata_q <= acc_rdata;
                err_q   <= acc_err;
                if (acc_we) begin
                    mem_q[acc_idx] <= acc_wword;
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a driver issues requests and pushes model responses; a monitor pops
// and compares on every response handshake.
module tb_data_mem_responder;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned LAT    = 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int unsigned DEPTH2 = 16;
    localparam logic [31:0] BASE2  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_if bus ();
    data_mem_if bus2 ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH2), .LATENCY(0), .BASE_ADDR(BASE2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_m [DEPTH];
    logic [32:0] exp_q [$];
    int          acc_q [$];
    bit          rr_mode  = 1'b0;
    logic        rr_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        exp_q.delete();
        acc_q.delete();
    endtask

    // Reference behaviour: plain range arithmetic on 64-bit values, byte-lane merge.
    task automatic model_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [32:0] resp);
        longint unsigned la = longint'(a);
        longint unsigned lo = longint'(BASE);
        longint unsigned hi = lo + longint'(DEPTH) * 4;
        int idx;
        if ((a % 4) != 0 || la < lo || la >= hi) begin
            resp = {1'b1, 32'h0};
        end else begin
            idx = int'((la - lo) / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
                resp = {1'b0, 32'h0};
            end else begin
                resp = {1'b0, mem_m[idx]};
            end
        end
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int n = 0;
        logic [32:0] r;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            fail("req_accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        model_access(w, a, d, s, r);
        exp_q.push_back(r);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_write = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Zero-latency throughput: request held valid, one response every second cycle.
    task automatic zero_lat_phase(input logic [31:0] a, input logic e, input string name);
        @(negedge clk);
        bus2.req_addr  = a;
        bus2.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check({name, "_resp_valid"}, bus2.resp_valid, ((i % 2) == 0));
            check({name, "_req_ready"}, bus2.req_ready, ((i % 2) != 0));
            if (bus2.resp_valid) begin
                check({name, "_err"}, bus2.resp_err, e);
                check({name, "_rdata"}, bus2.resp_rdata, 32'h0);
            end
        end
        @(negedge clk);
        bus2.req_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // resp_ready driver: directed value or random backpressure.
    initial begin
        bus.resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.resp_ready = rr_mode ? 1'($urandom_range(0, 1)) : rr_force;
        end
    end

    // Monitor: latency, hold-while-stalled, scoreboard compare, return to idle.
    initial begin
        bit          pv  = 1'b0;
        bit          phs = 1'b0;
        logic [31:0] prd = 32'h0;
        logic        perr = 1'b0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                pv  = 1'b0;
                phs = 1'b0;
                continue;
            end
            if (phs) check("idle_after_handshake", {bus.resp_valid, bus.req_ready}, 32'b01);
            if (bus.resp_valid) begin
                check("req_ready_low_in_resp", bus.req_ready, 1'b0);
                if (!pv) begin
                    if (acc_q.size() == 0) fail("unexpected_resp_valid");
                    else check("latency", cyc - acc_q.pop_front(), LAT);
                end else if (!phs) begin
                    check("hold_rdata", bus.resp_rdata, prd);
                    check("hold_err", bus.resp_err, perr);
                end
                if (bus.resp_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("resp_without_request");
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", bus.resp_rdata, e[31:0]);
                        check("err", bus.resp_err, e[32]);
                    end
                end
            end
            pv   = bus.resp_valid;
            phs  = bus.resp_valid && bus.resp_ready;
            prd  = bus.resp_rdata;
            perr = bus.resp_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_wstrb  = 4'h0;
        bus2.req_valid = 1'b0;
        bus2.req_write = 1'b0;
        bus2.req_addr  = BASE2;
        bus2.req_wdata = 32'h0;
        bus2.req_wstrb = 4'h0;
        bus2.resp_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_resp_valid", bus.resp_valid, 1'b0);
        check("reset_rdata", bus.resp_rdata, 32'h0);
        check("reset_err", bus.resp_err, 1'b0);

        // Zero-latency instance: last word in range, just past the end, just below base.
        zero_lat_phase(BASE2 + 32'(DEPTH2 * 4) - 32'd4, 1'b0, "lat0_last");
        zero_lat_phase(BASE2 + 32'(DEPTH2 * 4), 1'b1, "lat0_past_end");
        zero_lat_phase(BASE2 - 32'd4, 1'b1, "lat0_below_base");

        // Directed: load, byte-strobe merge, errors, no-op strobe.
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        issue(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b1111);
        issue(1'b1, 32'h20, 32'h0000_0055, 4'b0001);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        issue(1'b1, 32'h0, 32'hCAFE_F00D, 4'b1111);
        issue(1'b0, 32'h22, 32'h0, 4'h0);
        issue(1'b0, 32'h400, 32'h0, 4'h0);
        issue(1'b1, 32'h400, 32'h1111_2222, 4'b1111);
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        issue(1'b0, 32'h3FC, 32'h0, 4'h0);
        drain();

        // Backpressure: stall the response, pulse req_valid, then release.
        rr_force = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        r = 0;
        while (!bus.resp_valid && r < 50) begin
            @(negedge clk);
            #1;
            r++;
        end
        if (!bus.resp_valid) fail("bp_resp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = ((i % 2) == 0);
            bus.req_write = 1'b1;
            bus.req_addr  = 32'h20;
            bus.req_wdata = 32'h0BAD_0BAD;
            bus.req_wstrb = 4'hF;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        rr_force = 1'b1;
        drain();
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        drain();

        // Randomised traffic with random response backpressure.
        rr_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (r == 1) a = 32'h400 + ($urandom & 32'h0000_FFFC);
            else if (r < 6)  a = 32'($urandom_range(0, 15)) * 4;
            else             a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            issue(1'($urandom_range(0, 9) < 4), a, $urandom, 4'($urandom));
        end
        rr_mode = 1'b0;
        rr_force = 1'b1;
        drain();

        // Reset during WAIT discards an uncommitted store.
        issue(1'b1, 32'h8, 32'hA5A5_A5A5, 4'hF);
        drain();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h8;
        bus.req_wdata = 32'h1234_5678;
        bus.req_wstrb = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #1;
        check("rst_wait_req_ready", bus.req_ready, 1'b1);
        check("rst_wait_resp_valid", bus.resp_valid, 1'b0);
        issue(1'b0, 32'h8, 32'h0, 4'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
